// File: rtl/fpu_issue_ctrl.sv
// Credit-based issue controller between the operand transactor and the fpu core; results return in order.
// Optional counters (stat_issued/stat_exc/stat_stall, stat_clear) are built when FPU_ISSUE_STATS_EN is defined.
module fpu_issue_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int FPU_LATENCY = 4,
  parameter int REQ_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [71:0]           req_data,
  output logic [DATA_WIDTH-1:0] fpu_opa,
  output logic [DATA_WIDTH-1:0] fpu_opb,
  output logic [2:0]            fpu_op,
  output logic [1:0]            fpu_rmode,
  output logic                  fpu_start,
  input  logic [DATA_WIDTH-1:0] fpu_out,
  input  logic [7:0]            fpu_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH+7:0] rsp_data,
  output logic                  busy
`ifdef FPU_ISSUE_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_exc,
  output logic [31:0]           stat_stall
`endif
);

  localparam int RQA = $clog2(REQ_DEPTH);
  localparam int RSA = $clog2(RSP_DEPTH);
  localparam logic [RSA+1:0] CREDITS = (RSA+2)'(RSP_DEPTH);

  logic [68:0]           req_mem_q [REQ_DEPTH];
  logic [RQA:0]          req_wr_q, req_rd_q;
  logic [68:0]           req_head;
  logic                  req_empty, req_full, req_push, issue, credit_ok;
  logic [DATA_WIDTH+7:0] rsp_mem_q [RSP_DEPTH];
  logic [RSA:0]          rsp_wr_q, rsp_rd_q, rsp_count, inflight_q, inflight_d;
  logic                  rsp_empty, rsp_full, rsp_pop, capture;
  logic [FPU_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] fpu_opa_q, fpu_opb_q;
  logic [2:0]            fpu_op_q;
  logic [1:0]            fpu_rmode_q;
  logic                  fpu_start_q;
  logic                  unused_rsv;

  assign unused_rsv = ^req_data[71:69];

  assign req_empty = (req_wr_q == req_rd_q);
  assign req_full  = (req_wr_q[RQA] != req_rd_q[RQA]) && (req_wr_q[RQA-1:0] == req_rd_q[RQA-1:0]);
  assign req_ready = !req_full;
  assign req_push  = req_valid && !req_full;
  assign req_head  = req_mem_q[req_rd_q[RQA-1:0]];

  // Every op in flight owns a response slot, so a capture can never find the FIFO full.
  assign rsp_count = rsp_wr_q - rsp_rd_q;
  assign credit_ok = ({1'b0, rsp_count} + {1'b0, inflight_q}) < CREDITS;
  assign issue     = !req_empty && credit_ok;

  assign rsp_empty = (rsp_wr_q == rsp_rd_q);
  assign rsp_full  = (rsp_wr_q[RSA] != rsp_rd_q[RSA]) && (rsp_wr_q[RSA-1:0] == rsp_rd_q[RSA-1:0]);
  assign rsp_valid = !rsp_empty;
  assign rsp_data  = rsp_mem_q[rsp_rd_q[RSA-1:0]];
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign capture   = vld_q[FPU_LATENCY-1];

  assign fpu_opa   = fpu_opa_q;
  assign fpu_opb   = fpu_opb_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_rmode = fpu_rmode_q;
  assign fpu_start = fpu_start_q;
  assign busy      = !req_empty || (inflight_q != '0) || !rsp_empty;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = fpu_start_q;
    for (int i = 1; i < FPU_LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !capture)      inflight_d = inflight_q + 1'b1;
    else if (!issue && capture) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (req_push) req_mem_q[req_wr_q[RQA-1:0]] <= req_data[68:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_wr_q    <= '0;
      req_rd_q    <= '0;
      rsp_wr_q    <= '0;
      rsp_rd_q    <= '0;
      inflight_q  <= '0;
      vld_q       <= '0;
      fpu_opa_q   <= '0;
      fpu_opb_q   <= '0;
      fpu_op_q    <= '0;
      fpu_rmode_q <= '0;
      fpu_start_q <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) rsp_mem_q[i] <= '0;
    end else begin
      if (req_push) req_wr_q <= req_wr_q + 1'b1;
      if (issue) begin
        req_rd_q    <= req_rd_q + 1'b1;
        fpu_opa_q   <= DATA_WIDTH'(req_head[63:32]);
        fpu_opb_q   <= DATA_WIDTH'(req_head[31:0]);
        fpu_op_q    <= req_head[66:64];
        fpu_rmode_q <= req_head[68:67];
      end
      fpu_start_q <= issue;
      vld_q       <= vld_d;
      inflight_q  <= inflight_d;
      if (capture) begin
        rsp_mem_q[rsp_wr_q[RSA-1:0]] <= {fpu_flags, fpu_out};
        rsp_wr_q <= rsp_wr_q + 1'b1;
      end
      if (rsp_pop) rsp_rd_q <= rsp_rd_q + 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) assert (!(capture && rsp_full && !rsp_pop));
  end
`endif

`ifdef FPU_ISSUE_STATS_EN
  logic [31:0] st_iss_q, st_exc_q, st_stall_q;
  logic        exc_hit, stall_hit;

  assign exc_hit   = capture && ((|fpu_flags[7:3]) || fpu_flags[0]);
  assign stall_hit = !req_empty && !credit_ok;

  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      st_iss_q   <= '0;
      st_exc_q   <= '0;
      st_stall_q <= '0;
    end else begin
      if (issue && (st_iss_q != '1))       st_iss_q   <= st_iss_q + 1'b1;
      if (exc_hit && (st_exc_q != '1))     st_exc_q   <= st_exc_q + 1'b1;
      if (stall_hit && (st_stall_q != '1)) st_stall_q <= st_stall_q + 1'b1;
    end
  end

  assign stat_issued = st_iss_q;
  assign stat_exc    = st_exc_q;
  assign stat_stall  = st_stall_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: behavioural fpu stub, in-order scoreboard, vector table and corner sequences.
module tb_fpu_issue_ctrl;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [71:0] req_data;
  logic [31:0] fpu_opa, fpu_opb, fpu_out;
  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic        fpu_start;
  logic [7:0]  fpu_flags;
  logic        rsp_valid, rsp_ready;
  logic [39:0] rsp_data;
  logic        busy;
`ifdef FPU_ISSUE_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_issued, stat_exc, stat_stall;
`endif

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.DATA_WIDTH(32), .FPU_LATENCY(LAT), .REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_start(fpu_start), .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
`ifdef FPU_ISSUE_STATS_EN
    , .stat_clear(stat_clear), .stat_issued(stat_issued), .stat_exc(stat_exc), .stat_stall(stat_stall)
`endif
  );

  int n_cmp = 0, n_fail = 0, n_acc = 0, n_start = 0, n_rsp = 0, cyc = 0;
  logic [39:0] exp_q[$];
  logic [68:0] iss_q[$];
  logic [39:0] sched_d [64];
  logic        sched_v [64];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [39:0] exp;
  } vec_t;
  vec_t tbl [5];

  // The pretend fpu core: two known IEEE cases, otherwise an easily hand-computed mix.
  function automatic logic [39:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic [1:0] rm);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 3'd0) return {8'h00, 32'h4040_0000};
    if (op == 3'd3 && b == 32'h0) return {8'h88, 32'h7F80_0000};
    return {op, 3'b000, rm, a ^ b ^ {29'b0, op}};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [1:0] rm);
    logic [2:0] rsv;
    bit ok;
    rsv = 3'($urandom);
    ok = 1'b0;
    req_data  = {rsv, rm, op, a, b};
    req_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!ok) flag_fail("request_accept_timeout");
  endtask

  task automatic push_rand();
    logic [31:0] b;
    b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    push_op($urandom, b, 3'($urandom), 2'($urandom));
  endtask

  task automatic wait_rsp(input int target, input string name);
    for (int t = 0; t < 3000; t++) begin
      if (n_rsp >= target) return;
      @(posedge clk);
      #1;
    end
    flag_fail(name);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_fpu_start"}, fpu_start, 0);
    chk({tag, "_fpu_operands"}, {fpu_rmode, fpu_op, fpu_opa, fpu_opb}, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // fpu stub: returns the result exactly LAT cycles after each start, garbage otherwise.
  always @(posedge clk) begin
    logic [63:0] junk;
    cyc = cyc + 1;
    #1;
    junk = {$urandom, $urandom};
    if (sched_v[cyc % 64]) begin
      {fpu_flags, fpu_out} = sched_d[cyc % 64];
      sched_v[cyc % 64] = 1'b0;
    end else begin
      {fpu_flags, fpu_out} = junk[39:0];
    end
  end

  // Scoreboard: issue order and response order must both follow acceptance order.
  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready) begin
        exp_q.push_back(fpu_model(req_data[63:32], req_data[31:0], req_data[66:64], req_data[68:67]));
        iss_q.push_back(req_data[68:0]);
        n_acc++;
      end
      if (fpu_start) begin
        n_start++;
        sched_d[(cyc + LAT) % 64] = fpu_model(fpu_opa, fpu_opb, fpu_op, fpu_rmode);
        sched_v[(cyc + LAT) % 64] = 1'b1;
        if (iss_q.size() == 0) flag_fail("issue_without_request");
        else chk("issue_operands", {fpu_rmode, fpu_op, fpu_opa, fpu_opb}, iss_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) flag_fail("response_without_request");
        else chk("response_in_order", rsp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, s0, r0, cnt;
    bit found;
    bit done;

    tbl[0] = '{32'h3F80_0000, 32'h4000_0000, 3'd0, 2'd0, 40'h00_4040_0000};
    tbl[1] = '{32'h3F80_0000, 32'h0000_0000, 3'd3, 2'd0, 40'h88_7F80_0000};
    tbl[2] = '{32'h1234_5678, 32'h0000_FFFF, 3'd1, 2'd2, 40'h22_1234_A986};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 2'd3, 40'hE3_0000_0007};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 3'd0, 2'd1, 40'h01_0000_0000};

    for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_data = '0; rsp_ready = 1'b1;
`ifdef FPU_ISSUE_STATS_EN
    stat_clear = 1'b0;
`endif
    step(3);
    chk_reset_state("reset");
    reset = 1'b0;
    step(1);

    // Single op with exact latency and busy drop.
    a0 = n_acc; s0 = n_start;
    req_data  = {3'b101, 2'd0, 3'd0, 32'h3F80_0000, 32'h4000_0000};
    req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
    step(LAT + 1);
    chk("single_rsp_not_early", rsp_valid, 0);
    step(1);
    chk("single_rsp_on_time", rsp_valid, 1);
    chk("single_rsp_data", rsp_data, 40'h00_4040_0000);
    chk("single_busy_while_pending", busy, 1);
    step(1);
    chk("single_busy_after_pop", busy, 0);
    chk("single_accept_count", n_acc - a0, 1);
    chk("single_start_count", n_start - s0, 1);

`ifdef FPU_ISSUE_STATS_EN
    stat_clear = 1'b1; step(1); stat_clear = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      push_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rm);
      found = 1'b0;
      for (int t = 0; t < 50; t++) begin
        if (rsp_valid) begin found = 1'b1; break; end
        step(1);
      end
      if (found) chk($sformatf("vec%0d_rsp_data", i), rsp_data, tbl[i].exp);
      else flag_fail($sformatf("vec%0d_rsp_timeout", i));
      step(2);
      chk($sformatf("vec%0d_idle", i), busy, 0);
    end
`ifdef FPU_ISSUE_STATS_EN
    chk("stat_exc_after_table", stat_exc, 4);
    stat_clear = 1'b1; step(1); stat_clear = 1'b0;
`endif

    // Backpressure: credits cap issues at the response depth.
    rsp_ready = 1'b0;
    a0 = n_acc; s0 = n_start; r0 = n_rsp;
    for (int i = 0; i < 8; i++) push_rand();
    req_data  = {3'b000, 2'd1, 3'd2, 32'hCAFE_0001, 32'h0BAD_F00D};
    req_valid = 1'b1;
    step(20);
    chk("bp_req_ready_low", req_ready, 0);
    chk("bp_accepted", n_acc - a0, 8);
    chk("bp_fpu_starts", n_start - s0, 4);
    chk("bp_no_responses", n_rsp - r0, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    push_rand();
    push_rand();
    wait_rsp(r0 + 10, "bp_drain_timeout");
    step(3);
    chk("bp_drained", n_rsp - r0, 10);
    chk("bp_fpu_starts_total", n_start - s0, 10);
    chk("bp_idle", busy, 0);
`ifdef FPU_ISSUE_STATS_EN
    chk("stat_issued_bp", stat_issued, 10);
    chk("stat_stall_nonzero", stat_stall != 0, 1);
    r0 = n_rsp;
    req_data  = {3'b000, 2'd0, 3'd1, 32'h1111_1111, 32'h2222_2222};
    req_valid = 1'b1;
    step(1);
    req_valid  = 1'b0;
    stat_clear = 1'b1;
    step(1);
    stat_clear = 1'b0;
    chk("stat_clear_beats_issue", stat_issued, 0);
    wait_rsp(r0 + 1, "stat_clear_rsp_timeout");
    chk("stat_issued_after_clear", stat_issued, 0);
`endif

    // Streaming back-to-back requests.
    s0 = n_start; r0 = n_rsp;
    for (int i = 0; i < 16; i++) push_rand();
    wait_rsp(r0 + 16, "stream_timeout");
    chk("stream_fpu_starts", n_start - s0, 16);
    chk("stream_responses", n_rsp - r0, 16);

    // Reset with two ops in flight and one queued.
    step(2);
    push_rand();
    push_rand();
    push_rand();
    reset = 1'b1;
    step(1);
    chk_reset_state("midreset");
    exp_q.delete();
    iss_q.delete();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      step(1);
      if (rsp_valid) cnt++;
    end
    chk("midreset_no_stale_rsp", cnt, 0);
    r0 = n_rsp;
    push_op(32'h3F80_0000, 32'h4000_0000, 3'd0, 2'd0);
    wait_rsp(r0 + 1, "post_reset_rsp_timeout");

    // Random traffic with random consumer stalls.
    r0 = n_rsp;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
          push_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rsp_ready = ($urandom_range(0, 2) != 0);
          step(1);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_rsp(r0 + 120, "random_drain_timeout");
    step(3);
    chk("random_responses", n_rsp - r0, 120);
    chk("random_idle", busy, 0);
    chk("random_scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
